// File: rtl/harmonic_wavetable_scheduler.sv
// Harmonic additive oscillator: N phase accumulators share one sine ROM,
// stepped once per sample tick and mixed into one gain-weighted, saturated sample.
module harmonic_wavetable_scheduler #(
   parameter int N_HARM    = 4,
   parameter int ACC_W     = 24,
   parameter int MIX_SHIFT = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              sample_Clk,
   input  logic [23:0]       freq,
   input  logic [N_HARM-1:0] harm_en,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [3:0]        cfg_gain,
   output logic [11:0]       rom_addr,
   input  logic [15:0]       rom_data,
   output logic [15:0]       out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int KW = (N_HARM > 1) ? $clog2(N_HARM) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADDR, S_DATA, S_DONE} state_t;

   state_t                  r_state, w_next;
   logic [23:0]             r_freq;
   logic [N_HARM-1:0]       r_en;
   logic [KW-1:0]           r_k;
   logic [23:0]             r_phase [N_HARM];
   logic [3:0]              r_gain  [N_HARM];
   logic signed [ACC_W-1:0] r_acc;
   logic [11:0]             r_rom_addr;
   logic [15:0]             r_out;
   logic                    r_overrun;

   logic [23:0]             w_inc;
   logic signed [20:0]      w_prod;
   logic signed [ACC_W-1:0] w_shift;
   logic [15:0]             w_sat;
   logic                    w_last;

   localparam logic signed [ACC_W-1:0] MAX16 = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] MIN16 = ACC_W'(-32768);

   // Harmonic k steps by (k+1)*freq; the product is truncated to 24 bits.
   assign w_inc   = r_freq * (24'(r_k) + 24'd1);
   assign w_prod  = $signed(rom_data) * $signed({1'b0, r_gain[r_k]});
   assign w_shift = r_acc >>> MIX_SHIFT;
   assign w_last  = (r_k == KW'(N_HARM - 1));

   always_comb begin
      w_sat = w_shift[15:0];
      if (w_shift > MAX16)
         w_sat = 16'h7FFF;
      else if (w_shift < MIN16)
         w_sat = 16'h8000;
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (sample_Clk) w_next = S_LOAD;
         S_LOAD:  w_next = S_ADDR;
         S_ADDR:  w_next = S_DATA;
         S_DATA:  w_next = w_last ? S_DONE : S_ADDR;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < N_HARM; i++) begin
            r_phase[i] <= '0;
            r_gain[i]  <= 4'd8;
         end
         r_freq     <= '0;
         r_en       <= '0;
         r_k        <= '0;
         r_acc      <= '0;
         r_rom_addr <= '0;
         r_out      <= '0;
         r_overrun  <= 1'b0;
      end else begin
         if (cfg_we && ({1'b0, cfg_addr} < 5'(N_HARM)))
            r_gain[cfg_addr[KW-1:0]] <= cfg_gain;
         if (sample_Clk && (r_state != S_IDLE))
            r_overrun <= 1'b1;
         case (r_state)
            S_LOAD: begin
               r_freq <= freq;
               r_en   <= harm_en;
               r_acc  <= '0;
               r_k    <= '0;
            end
            S_ADDR: begin
               r_rom_addr <= r_phase[r_k][23:12];
               r_phase[r_k] <= r_en[r_k] ? (r_phase[r_k] + w_inc) : '0;
            end
            S_DATA: begin
               if (r_en[r_k])
                  r_acc <= r_acc + ACC_W'(w_prod);
               if (!w_last)
                  r_k <= r_k + KW'(1);
            end
            S_DONE:  r_out <= w_sat;
            default: ;
         endcase
      end
   end

   // The new sample is presented during the out_valid cycle and held afterwards.
   assign out       = (r_state == S_DONE) ? w_sat : r_out;
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign overrun   = r_overrun;
   assign rom_addr  = r_rom_addr;

endmodule

// File: tb/tb_harmonic_wavetable_scheduler.sv
// Directed, table-driven bench for harmonic_wavetable_scheduler with a behavioural ROM.
module tb_harmonic_wavetable_scheduler;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        sample_Clk;
   logic [23:0] freq;
   logic [3:0]  harm_en;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [3:0]  cfg_gain;
   logic [11:0] rom_addr;
   logic [15:0] rom_data;
   logic [15:0] out;
   logic        out_valid;
   logic        busy;
   logic        overrun;

   int mode;
   int checks   = 0;
   int failures = 0;

   harmonic_wavetable_scheduler #(.N_HARM(4), .ACC_W(24), .MIX_SHIFT(4)) dut (
      .Clk(Clk), .Reset(Reset), .sample_Clk(sample_Clk), .freq(freq),
      .harm_en(harm_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain),
      .rom_addr(rom_addr), .rom_data(rom_data), .out(out), .out_valid(out_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   always_comb begin
      rom_data = {4'h0, rom_addr};
      if (mode == 1)
         rom_data = 16'h7FFF;
      else if (mode == 2)
         rom_data = 16'h8000;
   end

   typedef struct {
      bit          rst;
      logic [3:0]  g;
      logic [3:0]  en;
      int          md;
      logic [15:0] exp_out;
      logic [47:0] ea;
      bit          chk_a;
      int          wcyc;
      logic [3:0]  wa;
      logic [3:0]  wg;
   } vec_t;

   vec_t tbl [12];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic write_gain(input logic [3:0] a, input logic [3:0] g);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_gain = g;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int          early;
      logic [11:0] got [4];
      if (v.rst) begin
         Reset = 1'b1;
         step();
         Reset = 1'b0;
      end
      if (v.g != 4'd0)
         for (int i = 0; i < 4; i++) write_gain(4'(i), v.g);
      harm_en    = v.en;
      freq       = 24'h001000;
      mode       = v.md;
      sample_Clk = 1'b1;
      early      = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         sample_Clk = 1'b0;
         cfg_we     = (c == v.wcyc);
         cfg_addr   = v.wa;
         cfg_gain   = v.wg;
         if (c == 3 || c == 5 || c == 7 || c == 9)
            got[(c - 3) / 2] = rom_addr;
         if (c < 10 && out_valid)
            early++;
      end
      chk($sformatf("v%0d_early_valid", idx), early, 0);
      chk($sformatf("v%0d_valid_t10", idx), out_valid, 1);
      chk($sformatf("v%0d_out", idx), out, v.exp_out);
      step();
      cfg_we = 1'b0;
      chk($sformatf("v%0d_valid_off", idx), out_valid, 0);
      chk($sformatf("v%0d_out_held", idx), out, v.exp_out);
      chk($sformatf("v%0d_idle", idx), busy, 0);
      if (v.chk_a)
         for (int i = 0; i < 4; i++)
            chk($sformatf("v%0d_addr%0d", idx, i), got[i], v.ea[47-12*i -: 12]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [31:0] mask;
      //            rst   g     en    md exp_out   addresses k0..k3                       chk_a wc wa    wg
      tbl[0]  = '{1'b0, 4'd0, 4'hF, 0, 16'h0000, {12'd0, 12'd0, 12'd0,  12'd0},  1'b1, 0, 4'd0, 4'd0};
      tbl[1]  = '{1'b0, 4'd0, 4'hF, 0, 16'h0005, {12'd1, 12'd2, 12'd3,  12'd4},  1'b1, 0, 4'd0, 4'd0};
      tbl[2]  = '{1'b1, 4'd0, 4'hF, 0, 16'h0000, {12'd0, 12'd0, 12'd0,  12'd0},  1'b1, 0, 4'd0, 4'd0};
      tbl[3]  = '{1'b0, 4'd0, 4'h5, 0, 16'h0002, {12'd1, 12'd2, 12'd3,  12'd4},  1'b1, 0, 4'd0, 4'd0};
      tbl[4]  = '{1'b0, 4'd0, 4'hF, 0, 16'h0004, {12'd2, 12'd0, 12'd6,  12'd0},  1'b1, 0, 4'd0, 4'd0};
      tbl[5]  = '{1'b0, 4'd15,4'hF, 1, 16'h7FFF, 48'd0,                            1'b0, 0, 4'd0, 4'd0};
      tbl[6]  = '{1'b0, 4'd0, 4'hF, 2, 16'h8000, 48'd0,                            1'b0, 0, 4'd0, 4'd0};
      tbl[7]  = '{1'b0, 4'd0, 4'hF, 0, 16'h0000, {12'd0, 12'd0, 12'd0,  12'd0},  1'b1, 0, 4'd0, 4'd0};
      tbl[8]  = '{1'b0, 4'd0, 4'hF, 0, 16'h0003, {12'd1, 12'd2, 12'd3,  12'd4},  1'b1, 0, 4'd0, 4'd0};
      tbl[9]  = '{1'b0, 4'd0, 4'hF, 0, 16'h0005, {12'd2, 12'd4, 12'd6,  12'd8},  1'b1, 4, 4'd1, 4'd0};
      tbl[10] = '{1'b0, 4'd0, 4'hF, 0, 16'h0007, {12'd3, 12'd6, 12'd9,  12'd12}, 1'b1, 9, 4'd3, 4'd0};
      tbl[11] = '{1'b0, 4'd0, 4'hF, 0, 16'h0002, {12'd4, 12'd8, 12'd12, 12'd16}, 1'b1, 0, 4'd0, 4'd0};

      Reset = 1'b1; sample_Clk = 1'b0; freq = '0; harm_en = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_gain = '0; mode = 0;
      step();
      step();
      chk("rst_out", out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_rom_addr", rom_addr, 0);
      Reset = 1'b0;
      step();

      for (int v = 0; v <= 6; v++) run_frame(tbl[v], v);

      // Tick at t, ignored tick at t+3, accepted tick at t+12.
      sample_Clk = 1'b1;
      mask = '0;
      for (int c = 1; c <= 23; c++) begin
         step();
         sample_Clk = (c == 3 || c == 12);
         if (out_valid) mask[c] = 1'b1;
         if (c == 3) chk("ovr_before", overrun, 0);
         if (c == 4) begin
            chk("ovr_set", overrun, 1);
            chk("ovr_busy", busy, 1);
         end
      end
      chk("ovr_pulses", mask, (32'd1 << 10) | (32'd1 << 22));
      chk("ovr_sticky", overrun, 1);
      chk("ovr_out", out, 16'h8000);

      // Reset in the middle of a frame.
      mode = 0; harm_en = 4'hF; freq = 24'h001000;
      sample_Clk = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         sample_Clk = 1'b0;
         if (c == 5) Reset = 1'b1;
      end
      step();
      Reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out", out, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_rom_addr", rom_addr, 0);
      step();
      chk("mid_rst_no_late_valid", out_valid, 0);

      write_gain(4'd4, 4'd15);
      write_gain(4'd2, 4'd0);

      for (int v = 7; v <= 11; v++) run_frame(tbl[v], v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/harmonic_wavetable_scheduler.md
Name: harmonic_wavetable_scheduler

Overview:
- Time-multiplexes one shared 4096x16 sine wavetable ROM between N harmonic phase accumulators.
- Harmonic k (0-based) runs at (k+1)·freq.
- On each sample tick it steps every harmonic, reads the ROM once per harmonic, and produces one gain-weighted, saturated mix sample.
- Sits between the note/frequency front end and the audio output path. It replaces one dedicated ROM per harmonic.

Parameters:
- N_HARM, 4, number of harmonics sequenced (1..16).
- ACC_W, 24, mix accumulator width (signed).
- MIX_SHIFT, 4, arithmetic right shift applied to the accumulator before saturation.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- sample_Clk  in  1  one-Clk-cycle sample tick.
- freq  in  24  fundamental phase increment per sample.
- harm_en  in  N_HARM  per-harmonic enable.
- cfg_we  in  1  gain write strobe.
- cfg_addr  in  4  harmonic index for the gain write.
- cfg_gain  in  4  unsigned gain, 0..15.
- rom_addr  out  12  shared wavetable address.
- rom_data  in  16  signed ROM sample; valid exactly 1 Clk after rom_addr.
- out  out  16  signed mixed sample, held between updates.
- out_valid  out  1  one-cycle pulse when out updates.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset: applied at a Clk edge, regardless of state, including mid-frame.
  - Outputs cleared: out=0, out_valid=0, busy=0, overrun=0, rom_addr=0.
  - Internal state cleared: all phase[k]=0, acc=0, all gains=8, state=IDLE.
- FSM states: IDLE, LOAD, ADDR, DATA, DONE.
- IDLE: on sample_Clk=1, go to LOAD.
- LOAD (1 cycle):
  - freq_r<=freq; harm_en_r<=harm_en; acc<=0; k<=0.
  - freq and harm_en are frozen for the whole frame.
  - Next state ADDR.
- ADDR(k):
  - rom_addr<=phase[k][23:12], using the pre-update phase.
  - If harm_en_r[k]=1: phase[k]<=phase[k]+(k+1)·freq_r, mod 2^24.
  - If harm_en_r[k]=0: phase[k]<=0.
  - Next state DATA.
- DATA(k):
  - If harm_en_r[k]=1: acc<=acc+signed(rom_data)·gain[k]. The product is 21-bit signed, sign-extended to ACC_W.
  - If the harmonic is disabled, acc is unchanged.
  - If k=N_HARM-1, go to DONE; otherwise k<=k+1 and go to ADDR.
- DONE (1 cycle):
  - Compute s = acc >>> MIX_SHIFT (arithmetic shift).
  - out<=sat16(s): clamp to [-32768, 32767].
  - out_valid=1 in this cycle only.
  - Next state IDLE.
- Latency: tick seen at cycle t gives out_valid at cycle t+2+2·N_HARM, which is t+10 for N_HARM=4. Frame length is 2·N_HARM+2 cycles.
- Tick while busy (LOAD..DONE):
  - The tick is ignored; overrun<=1.
  - overrun is cleared only by Reset.
  - A tick in the same cycle as DONE is also ignored.
  - The next accepted tick is one seen in IDLE.
- Gain writes:
  - Accepted any cycle while cfg_we=1 and cfg_addr<N_HARM; the new gain is visible the next cycle.
  - A write during a frame applies to any DATA cycle strictly after the write cycle.
  - cfg_addr>=N_HARM is ignored.
- rom_addr holds its value outside ADDR.
- out holds its value between DONE cycles.
- Phase wrap: 24-bit modular; no flag.
- Increment (k+1)·freq_r is computed mod 2^24, by multiplier or repeated add; the result must be exact mod 2^24.

Test Plan:
- ROM model returns rom_data={4'h0,rom_addr}; gains 8, harm_en=4'hF, freq=24'h001000. Issue two ticks 20 cycles apart:
  - Frame 1 gives out=0.
  - Frame 2 reads addrs 1,2,3,4; acc=80, so out=5.
  - Both out_valid pulses land exactly 10 cycles after their tick.
- Same setup with harm_en=4'b0101 on frame 2: acc=8·(1+3)=32, so out=2. The next frame with harm_en=4'hF reads addrs 2,0,6,0: phases of harmonics 1 and 3 were cleared.
- ROM constant 16'h7FFF, gains 15, all enabled: acc=1966020, so out=16'h7FFF. ROM constant 16'h8000: acc=-1966080, so out=16'h8000.
- Tick at t, second tick at t+3:
  - Only one out_valid, at t+10.
  - overrun=1 from t+4 and stays high through later frames.
  - A tick at t+12 is accepted normally.
- Assert Reset at t+5 mid-frame: the next cycle shows busy=0, out=0, overrun=0, and no out_valid. A following tick with ROM model 1 and freq=24'h001000 gives out=0, since all phases restarted at 0.
- Write cfg_gain=0 to harmonic 2 and 15 to cfg_addr=4 (ignored), then run ROM model 1 frame 2: acc=8·(1+2+4)=56, so out=3.
